uart_tx_sched: RTL and testbench

//  Round-robin scheduler that shares one uart_tx transmitter among NUM_REQ byte sources.

---
 rtl/uart_tx_sched.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_sched.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx among NUM_REQ byte sources.
// It captures the winning byte and issues the ld_tx_datareg -> byte_ready -> t_byte
// pulses. It then holds the transmitter for one frame time before it arbitrates again.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a pending request while tx_hold is low
// LOAD  | byte captured; ld_tx_datareg and req_ack pulse this cycle
// READY | byte_ready pulses this cycle
// START | t_byte pulses this cycle; frame counter gets loaded
// WAIT  | frame in flight; frame_done pulses in the last cycle
module uart_tx_sched #(
    parameter int NUM_REQ      = 4,
    parameter int FRAME_CYCLES = 10
) (
    input  logic                   clk,
    input  logic                   reset_,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic                   tx_hold,
    output logic [NUM_REQ-1:0]     req_ack,
    output logic [7:0]             data_bus,
    output logic                   ld_tx_datareg,
    output logic                   byte_ready,
    output logic                   t_byte,
    output logic                   busy,
    output logic                   frame_done
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(FRAME_CYCLES);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        READY = 3'd2,
        START = 3'd3,
        WAIT  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] req_ack_q, req_ack_d;
    logic [7:0]         data_bus_q, data_bus_d;
    logic               ld_q, ld_d;
    logic               br_q, br_d;
    logic               tb_q, tb_d;
    logic               busy_q, busy_d;
    logic               fd_q, fd_d;

    logic               found;
    logic [PTR_W-1:0]   win;
    logic [7:0]         win_byte;
    logic [NUM_REQ-1:0] win_onehot;
    int                 idx;

    // Pick the first pending requester at or after rr_ptr, wrapping around.
    always_comb begin
        found      = 1'b0;
        win        = '0;
        win_byte   = 8'h00;
        win_onehot = '0;
        idx        = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = PTR_W'(idx);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == PTR_W'(i)) begin
                win_byte      = req_data[8*i +: 8];
                win_onehot[i] = 1'b1;
            end
        end
    end

    // Next-state and next-output logic; every output is registered from its _d.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        cnt_d      = cnt_q;
        req_ack_d  = '0;
        data_bus_d = data_bus_q;
        ld_d       = 1'b0;
        br_d       = 1'b0;
        tb_d       = 1'b0;
        fd_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!tx_hold && found) begin
                    state_d    = LOAD;
                    data_bus_d = win_byte;
                    req_ack_d  = win_onehot;
                    ld_d       = 1'b1;
                    rr_ptr_d   = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                end
            end
            LOAD: begin
                state_d = READY;
                br_d    = 1'b1;
            end
            READY: begin
                state_d = START;
                tb_d    = 1'b1;
            end
            START: begin
                state_d = WAIT;
                cnt_d   = CNT_W'(FRAME_CYCLES - 1);
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    // frame_done is registered, so raise it on the way into the zero count.
                    fd_d  = (cnt_q == CNT_W'(1));
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset_) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            cnt_q      <= '0;
            req_ack_q  <= '0;
            data_bus_q <= 8'h00;
            ld_q       <= 1'b0;
            br_q       <= 1'b0;
            tb_q       <= 1'b0;
            busy_q     <= 1'b0;
            fd_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            cnt_q      <= cnt_d;
            req_ack_q  <= req_ack_d;
            data_bus_q <= data_bus_d;
            ld_q       <= ld_d;
            br_q       <= br_d;
            tb_q       <= tb_d;
            busy_q     <= busy_d;
            fd_q       <= fd_d;
        end
    end

    assign req_ack       = req_ack_q;
    assign data_bus      = data_bus_q;
    assign ld_tx_datareg = ld_q;
    assign byte_ready    = br_q;
    assign t_byte        = tb_q;
    assign busy          = busy_q;
    assign frame_done    = fd_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with NUM_REQ=4 and FRAME_CYCLES=10.
module tb_uart_tx_sched;

    localparam int NR = 4;
    localparam int FC = 10;

    logic          clk = 1'b0;
    logic          reset_;
    logic [NR-1:0] req_valid;
    logic [8*NR-1:0] req_data;
    logic          tx_hold;
    logic [NR-1:0] req_ack;
    logic [7:0]    data_bus;
    logic          ld_tx_datareg, byte_ready, t_byte, busy, frame_done;

    int checks = 0;
    int errors = 0;

    uart_tx_sched #(.NUM_REQ(NR), .FRAME_CYCLES(FC)) dut (
        .clk           (clk),
        .reset_        (reset_),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .tx_hold       (tx_hold),
        .req_ack       (req_ack),
        .data_bus      (data_bus),
        .ld_tx_datareg (ld_tx_datareg),
        .byte_ready    (byte_ready),
        .t_byte        (t_byte),
        .busy          (busy),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_values();
        chk("rst_ack",  32'(req_ack), 32'h0);
        chk("rst_data", 32'(data_bus), 32'h0);
        chk("rst_ld",   32'(ld_tx_datareg), 32'h0);
        chk("rst_br",   32'(byte_ready), 32'h0);
        chk("rst_tb",   32'(t_byte), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_fd",   32'(frame_done), 32'h0);
    endtask

    // Called with the block in an IDLE cycle and the request already presented.
    // The requester drops its valid on seeing ack. tx_hold is raised before WAIT
    // tick hold_at (negative means never).
    task automatic serve(input int id, input logic [7:0] b, input int hold_at);
        logic [NR-1:0] oh;
        oh = '0;
        oh[id] = 1'b1;
        tick();
        chk("ack",       32'(req_ack), 32'(oh));
        chk("data",      32'(data_bus), 32'(b));
        chk("ld",        32'(ld_tx_datareg), 32'h1);
        chk("busy_load", 32'(busy), 32'h1);
        req_valid[id] = 1'b0;
        tick();
        chk("ack_clr",   32'(req_ack), 32'h0);
        chk("ld_clr",    32'(ld_tx_datareg), 32'h0);
        chk("br",        32'(byte_ready), 32'h1);
        tick();
        chk("br_clr",    32'(byte_ready), 32'h0);
        chk("tb",        32'(t_byte), 32'h1);
        for (int k = 0; k < FC; k++) begin
            if (k == hold_at) tx_hold = 1'b1;
            tick();
            chk("tb_wait",   32'(t_byte), 32'h0);
            chk("busy_wait", 32'(busy), 32'h1);
            chk("fd_wait",   32'(frame_done), (k == FC - 1) ? 32'h1 : 32'h0);
            chk("data_hold", 32'(data_bus), 32'(b));
        end
        tick();
        chk("busy_idle", 32'(busy), 32'h0);
        chk("fd_idle",   32'(frame_done), 32'h0);
    endtask

    initial begin
        reset_    = 1'b1;
        req_valid = '0;
        req_data  = '0;
        tx_hold   = 1'b0;
        tick();
        tick();
        reset_ = 1'b0;
        chk_reset_values();

        // Test 1: one requester (2) with A5.
        req_data  = 32'h00A5_0000;
        req_valid = 4'b0100;
        serve(2, 8'hA5, -1);

        // Test 2: all four pending, starting from a fresh pointer.
        reset_ = 1'b1;
        tick();
        reset_ = 1'b0;
        req_data  = 32'h4433_2211;
        req_valid = 4'b1111;
        serve(0, 8'h11, -1);
        serve(1, 8'h22, -1);
        serve(2, 8'h33, -1);
        serve(3, 8'h44, -1);

        // Test 3: serving 3 wraps the pointer to 0, so 0 goes before 3.
        req_data  = 32'h9900_0077;
        req_valid = 4'b1000;
        serve(3, 8'h99, -1);
        req_valid = 4'b1001;
        serve(0, 8'h77, -1);
        serve(3, 8'h99, -1);

        // Test 4: tx_hold blocks the start of a frame.
        tx_hold   = 1'b1;
        req_data  = 32'h0000_00C3;
        req_valid = 4'b0001;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("hold_ack",  32'(req_ack), 32'h0);
            chk("hold_busy", 32'(busy), 32'h0);
        end
        tx_hold = 1'b0;
        serve(0, 8'hC3, -1);

        // Test 5: tx_hold raised mid-WAIT; the frame completes and the block idles.
        req_data  = 32'h00E7_5A00;
        req_valid = 4'b0110;
        serve(1, 8'h5A, 3);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("held_ack",  32'(req_ack), 32'h0);
            chk("held_busy", 32'(busy), 32'h0);
        end

        // Test 6: reset during WAIT aborts the frame and clears the pointer.
        tx_hold = 1'b0;
        tick();
        chk("t6_ack",  32'(req_ack), 32'h4);
        chk("t6_data", 32'(data_bus), 32'hE7);
        req_valid[2] = 1'b0;
        tick();
        tick();
        tick();
        tick();
        chk("t6_busy", 32'(busy), 32'h1);
        req_data  = 32'hD200_B100;
        req_valid = 4'b1010;
        reset_ = 1'b1;
        tick();
        reset_ = 1'b0;
        chk_reset_values();
        serve(1, 8'hB1, -1);
        serve(3, 8'hD2, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
